// File: rtl/dl11_console.sv
// ----------------------------------------------------------------------------
// dl11_console -- DL11-style console serial line in the iopage.
//
// Registers (word addresses, low 13 bits of the physical address):
//   17560 TKS  receiver status : bit7 done (ro), bit6 IE (rw)
//   17562 TKB  receiver buffer : bit15 error, bit14 overrun, bit13 framing,
//                                bits7:0 data (ro; any read clears done and errors)
//   17564 TPS  transmit status : bit7 ready (ro), bit6 IE (rw)
//   17566 TPB  transmit buffer : write-only, low byte starts an 8N1 frame
//
// Ports:
//   clk, reset (async, active-low)
//   io_addr/io_data_in/io_data_out/io_rd/io_wr/io_byte_op/io_decode : bus side
//   rs232_tx / rs232_rx                                             : line side
//   int_req/int_ipl/int_vector, interrupt_ack_ipl                   : interrupts
// ----------------------------------------------------------------------------
module dl11_console #(
    parameter int         CLKS_PER_BIT = 16,
    parameter logic [7:0] RX_VECTOR    = 8'o060,
    parameter logic [7:0] TX_VECTOR    = 8'o064,
    parameter logic [7:0] INT_IPL      = 8'o004
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [12:0] io_addr,
    input  logic [15:0] io_data_in,
    output logic [15:0] io_data_out,
    input  logic        io_rd,
    input  logic        io_wr,
    input  logic        io_byte_op,
    output logic        io_decode,
    output logic        rs232_tx,
    input  logic        rs232_rx,
    output logic        int_req,
    output logic [7:0]  int_ipl,
    output logic [7:0]  int_vector,
    input  logic [7:0]  interrupt_ack_ipl
);

    localparam int              CNT_W     = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
    typedef enum logic [2:0] {RX_ARM, RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    // Transmit side
    tx_state_e        tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic [7:0]       tx_shift_q, tx_shift_d;
    logic             tx_line_q, tx_line_d;
    logic             tx_ready_q, tx_ready_d;
    logic             tx_ie_q, tx_ie_d;
    logic             tx_pend_q, tx_pend_d;

    // Receive side
    logic [1:0]       rx_sync_q;
    rx_state_e        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic [7:0]       rx_buf_q, rx_buf_d;
    logic             rx_done_q, rx_done_d;
    logic             rx_ovr_q, rx_ovr_d;
    logic             rx_frm_q, rx_frm_d;
    logic             rx_ie_q, rx_ie_d;
    logic             rx_pend_q, rx_pend_d;

    logic [1:0]  reg_sel;
    logic        wr_low, tks_wr, tps_wr, tpb_wr, tkb_rd, rx_in, ack;
    logic [15:0] rd_data;
    logic        unused_bits;

    assign io_decode = (io_addr[12:3] == 10'o1756);
    assign reg_sel   = io_addr[2:1];
    // A high-byte-only write touches none of the writable bits.
    assign wr_low    = io_wr & io_decode & ~(io_byte_op & io_addr[0]);
    assign tks_wr    = wr_low & (reg_sel == 2'd0);
    assign tps_wr    = wr_low & (reg_sel == 2'd2);
    assign tpb_wr    = wr_low & (reg_sel == 2'd3);
    assign tkb_rd    = io_rd & io_decode & (reg_sel == 2'd1);
    assign rx_in     = rx_sync_q[1];
    assign ack       = (interrupt_ack_ipl == INT_IPL) & (rx_pend_q | tx_pend_q);
    assign unused_bits = ^io_data_in[15:8];

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_line_d  = tx_line_q;
        tx_ready_d = tx_ready_q;
        tx_ie_d    = tx_ie_q;
        tx_pend_d  = tx_pend_q;
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_buf_d   = rx_buf_q;
        rx_done_d  = rx_done_q;
        rx_ovr_d   = rx_ovr_q;
        rx_frm_d   = rx_frm_q;
        rx_ie_d    = rx_ie_q;
        rx_pend_d  = rx_pend_q;

        // Writes to TPB outside IDLE fall through and are ignored.
        case (tx_state_q)
            TX_IDLE: if (tpb_wr && tx_ready_q) begin
                tx_shift_d = io_data_in[7:0];
                tx_ready_d = 1'b0;
                tx_line_d  = 1'b0;
                tx_cnt_d   = BIT_LAST;
                tx_state_d = TX_START;
            end
            TX_START: if (tx_cnt_q == '0) begin
                tx_line_d  = tx_shift_q[0];
                tx_cnt_d   = BIT_LAST;
                tx_bit_d   = 3'd0;
                tx_state_d = TX_DATA;
            end else tx_cnt_d = tx_cnt_q - CNT_W'(1);
            TX_DATA: if (tx_cnt_q == '0) begin
                tx_cnt_d = BIT_LAST;
                if (tx_bit_q == 3'd7) begin
                    tx_line_d  = 1'b1;
                    tx_state_d = TX_STOP;
                end else begin
                    tx_bit_d   = tx_bit_q + 3'd1;
                    tx_shift_d = tx_shift_q >> 1;
                    tx_line_d  = tx_shift_q[1];
                end
            end else tx_cnt_d = tx_cnt_q - CNT_W'(1);
            TX_STOP: if (tx_cnt_q == '0) begin
                tx_ready_d = 1'b1;
                tx_state_d = TX_IDLE;
            end else tx_cnt_d = tx_cnt_q - CNT_W'(1);
            default: tx_state_d = TX_IDLE;
        endcase

        if (tkb_rd) begin
            rx_done_d = 1'b0;
            rx_ovr_d  = 1'b0;
            rx_frm_d  = 1'b0;
        end

        // ARM insists on an idle-high line before hunting for a start bit,
        // so a line stuck low yields a single framing-error frame.
        case (rx_state_q)
            RX_ARM:  if (rx_in) rx_state_d = RX_IDLE;
            RX_IDLE: if (!rx_in) begin
                rx_cnt_d   = HALF_LAST;
                rx_bit_d   = 3'd0;
                rx_state_d = RX_START;
            end
            RX_START: if (rx_cnt_q == '0) begin
                rx_cnt_d   = BIT_LAST;
                rx_state_d = rx_in ? RX_IDLE : RX_DATA;
            end else rx_cnt_d = rx_cnt_q - CNT_W'(1);
            RX_DATA: if (rx_cnt_q == '0) begin
                rx_shift_d = {rx_in, rx_shift_q[7:1]};
                rx_cnt_d   = BIT_LAST;
                rx_bit_d   = rx_bit_q + 3'd1;
                if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
            end else rx_cnt_d = rx_cnt_q - CNT_W'(1);
            RX_STOP: if (rx_cnt_q == '0) begin
                // Completion overrides a same-edge TKB read.
                rx_buf_d   = rx_shift_q;
                rx_frm_d   = ~rx_in;
                rx_ovr_d   = rx_done_q & ~tkb_rd;
                rx_done_d  = 1'b1;
                rx_state_d = RX_ARM;
            end else rx_cnt_d = rx_cnt_q - CNT_W'(1);
            default: rx_state_d = RX_ARM;
        endcase

        if (tks_wr) rx_ie_d = io_data_in[6];
        if (tps_wr) tx_ie_d = io_data_in[6];

        // Ack retires whichever request int_vector currently names.
        if (ack) begin
            if (rx_pend_q) rx_pend_d = 1'b0;
            else           tx_pend_d = 1'b0;
        end
        if (tkb_rd) rx_pend_d = 1'b0;
        if ((rx_ie_d & rx_done_d) & ~(rx_ie_q & rx_done_q))  rx_pend_d = 1'b1;
        if ((tx_ie_d & tx_ready_d) & ~(tx_ie_q & tx_ready_q)) tx_pend_d = 1'b1;
        if (!rx_ie_d) rx_pend_d = 1'b0;
        if (!tx_ie_d) tx_pend_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_line_q  <= 1'b1;
            tx_ready_q <= 1'b1;
            tx_ie_q    <= 1'b0;
            tx_pend_q  <= 1'b0;
            rx_sync_q  <= 2'b11;
            rx_state_q <= RX_ARM;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_done_q  <= 1'b0;
            rx_ovr_q   <= 1'b0;
            rx_frm_q   <= 1'b0;
            rx_ie_q    <= 1'b0;
            rx_pend_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_line_q  <= tx_line_d;
            tx_ready_q <= tx_ready_d;
            tx_ie_q    <= tx_ie_d;
            tx_pend_q  <= tx_pend_d;
            rx_sync_q  <= {rx_sync_q[0], rs232_rx};
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_done_q  <= rx_done_d;
            rx_ovr_q   <= rx_ovr_d;
            rx_frm_q   <= rx_frm_d;
            rx_ie_q    <= rx_ie_d;
            rx_pend_q  <= rx_pend_d;
        end
    end

    // Shift registers and the receive buffer carry data only.
    always_ff @(posedge clk) begin
        tx_shift_q <= tx_shift_d;
        rx_shift_q <= rx_shift_d;
        rx_buf_q   <= rx_buf_d;
    end

    always_comb begin
        rd_data = 16'd0;
        case (reg_sel)
            2'd0: rd_data = {8'd0, rx_done_q, rx_ie_q, 6'd0};
            2'd1: rd_data = {rx_ovr_q | rx_frm_q, rx_ovr_q, rx_frm_q, 5'd0, rx_buf_q};
            2'd2: rd_data = {8'd0, tx_ready_q, tx_ie_q, 6'd0};
            default: rd_data = 16'd0;
        endcase
    end

    assign io_data_out = (io_rd && io_decode) ? rd_data : 16'd0;
    assign rs232_tx    = tx_line_q;
    assign int_req     = rx_pend_q | tx_pend_q;
    assign int_ipl     = int_req ? INT_IPL : 8'd0;
    assign int_vector  = rx_pend_q ? RX_VECTOR : (tx_pend_q ? TX_VECTOR : 8'd0);

endmodule

// File: tb/tb_dl11_console.sv
module tb_dl11_console;

    localparam logic [12:0] A_TKS = 13'o17560;
    localparam logic [12:0] A_TKB = 13'o17562;
    localparam logic [12:0] A_TPS = 13'o17564;
    localparam logic [12:0] A_TPB = 13'o17566;

    logic        clk = 1'b0;
    logic        reset;
    logic [12:0] io_addr;
    logic [15:0] io_data_in;
    logic [15:0] io_data_out;
    logic        io_rd, io_wr, io_byte_op, io_decode;
    logic        rs232_tx, rs232_rx;
    logic        int_req;
    logic [7:0]  int_ipl, int_vector, interrupt_ack_ipl;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dl11_console #(.CLKS_PER_BIT(16)) dut (
        .clk(clk), .reset(reset),
        .io_addr(io_addr), .io_data_in(io_data_in), .io_data_out(io_data_out),
        .io_rd(io_rd), .io_wr(io_wr), .io_byte_op(io_byte_op), .io_decode(io_decode),
        .rs232_tx(rs232_tx), .rs232_rx(rs232_rx),
        .int_req(int_req), .int_ipl(int_ipl), .int_vector(int_vector),
        .interrupt_ack_ipl(interrupt_ack_ipl)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0o, expected %0o", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input logic [12:0] a, output logic [15:0] v);
        io_addr = a;
        io_rd   = 1'b1;
        #1;
        v     = io_data_out;
        io_rd = 1'b0;
    endtask

    task automatic rd(input logic [12:0] a, output logic [15:0] v);
        io_addr = a;
        io_rd   = 1'b1;
        #1;
        v = io_data_out;
        @(posedge clk);
        #1;
        io_rd = 1'b0;
    endtask

    task automatic wr(input logic [12:0] a, input logic [15:0] d, input logic bop);
        io_addr    = a;
        io_data_in = d;
        io_byte_op = bop;
        io_wr      = 1'b1;
        @(posedge clk);
        #1;
        io_wr      = 1'b0;
        io_byte_op = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stopb);
        rs232_rx = 1'b0;
        repeat (16) tick();
        for (int i = 0; i < 8; i++) begin
            rs232_rx = d[i];
            repeat (16) tick();
        end
        rs232_rx = stopb;
        repeat (16) tick();
        rs232_rx = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [15:0] v;
        logic [9:0]  exp_frame;

        reset = 1'b0; io_addr = '0; io_data_in = '0; io_rd = 0; io_wr = 0;
        io_byte_op = 0; rs232_rx = 1'b1; interrupt_ack_ipl = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        tick();

        // Reset state
        check("idle data_out", io_data_out, 16'd0);
        check("reset tx line", {15'd0, rs232_tx}, 16'd1);
        check("reset int_req", {15'd0, int_req}, 16'd0);
        check("reset int_vector", {8'd0, int_vector}, 16'd0);
        peek(A_TPS, v); check("reset TPS", v, 16'o000200);
        peek(A_TKS, v); check("reset TKS", v, 16'o000000);
        io_addr = A_TPS; #1;
        check("decode TPS", {15'd0, io_decode}, 16'd1);
        io_addr = 13'o17570; #1;
        check("decode miss", {15'd0, io_decode}, 16'd0);
        tick();

        // Transmit 0x41; a second TPB write mid-frame must be ignored
        exp_frame = {1'b1, 8'h41, 1'b0};
        wr(A_TPB, 16'h0041, 1'b0);
        for (int c = 1; c <= 161; c++) begin
            if (c >= 9 && c <= 153 && ((c - 9) % 16) == 0)
                check($sformatf("tx bit %0d", (c - 9) / 16), {15'd0, rs232_tx},
                      {15'd0, exp_frame[(c - 9) / 16]});
            if (c == 40) begin io_addr = A_TPB; io_data_in = 16'h00FF; io_wr = 1'b1; end
            if (c == 41) io_wr = 1'b0;
            if (c == 160) begin peek(A_TPS, v); check("TPS busy N+160", v, 16'o000000); end
            if (c == 161) begin peek(A_TPS, v); check("TPS ready N+161", v, 16'o000200); end
            if (c < 161) tick();
        end
        tick();

        // High-byte write to TPB does not start a frame
        wr(13'o17567, 16'h4100, 1'b1);
        repeat (3) tick();
        check("hibyte tx idle", {15'd0, rs232_tx}, 16'd1);
        peek(A_TPS, v); check("hibyte TPS ready", v, 16'o000200);

        // Reset in the middle of a frame aborts asynchronously
        wr(A_TPB, 16'h0000, 1'b0);
        repeat (30) tick();
        check("midframe tx low", {15'd0, rs232_tx}, 16'd0);
        reset = 1'b0;
        #1;
        check("async reset tx", {15'd0, rs232_tx}, 16'd1);
        peek(A_TPS, v); check("async reset TPS", v, 16'o000200);
        tick();
        reset = 1'b1;
        repeat (4) tick();

        // Receive 0x5A
        send_byte(8'h5A, 1'b1);
        peek(A_TKS, v); check("rx TKS done", v, 16'o000200);
        rd(A_TKB, v);   check("rx TKB 5A", v, 16'o000132);
        peek(A_TKS, v); check("rx TKS cleared", v, 16'o000000);

        // Overrun: two frames without reading TKB
        send_byte(8'h31, 1'b1);
        send_byte(8'h32, 1'b1);
        rd(A_TKB, v);   check("overrun TKB", v, 16'o140062);
        peek(A_TKS, v); check("overrun TKS cleared", v, 16'o000000);

        // Short low glitch is rejected at the start-bit midpoint
        rs232_rx = 1'b0;
        repeat (3) tick();
        rs232_rx = 1'b1;
        repeat (40) tick();
        peek(A_TKS, v); check("glitch no done", v, 16'o000000);

        // Interrupts: both pending, rx first
        send_byte(8'h55, 1'b1);
        wr(A_TKS, 16'o000100, 1'b0);
        check("rx int_req", {15'd0, int_req}, 16'd1);
        check("rx int_vector", {8'd0, int_vector}, 16'o060);
        peek(A_TKS, v); check("TKS IE+done", v, 16'o000300);
        wr(A_TPS, 16'o000100, 1'b0);
        check("int_ipl", {8'd0, int_ipl}, 16'o004);
        interrupt_ack_ipl = 8'o005;
        tick();
        interrupt_ack_ipl = 8'o000;
        check("wrong-level ack", {8'd0, int_vector}, 16'o060);
        interrupt_ack_ipl = 8'o004;
        tick();
        interrupt_ack_ipl = 8'o000;
        check("ack1 vector", {8'd0, int_vector}, 16'o064);
        check("ack1 int_req", {15'd0, int_req}, 16'd1);
        interrupt_ack_ipl = 8'o004;
        tick();
        interrupt_ack_ipl = 8'o000;
        check("ack2 int_req", {15'd0, int_req}, 16'd0);
        check("ack2 int_ipl", {8'd0, int_ipl}, 16'd0);
        check("ack2 int_vector", {8'd0, int_vector}, 16'd0);

        // Line stuck low from reset: one framing-error frame only
        reset    = 1'b0;
        rs232_rx = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        repeat (400) tick();
        peek(A_TKS, v); check("stuck done", v, 16'o000200);
        rd(A_TKB, v);   check("stuck TKB", v, 16'o120000);
        repeat (300) tick();
        peek(A_TKS, v); check("stuck no repeat", v, 16'o000000);
        rs232_rx = 1'b1;
        repeat (4) tick();
        send_byte(8'h7E, 1'b1);
        rd(A_TKB, v);   check("recovered TKB", v, 16'o000176);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
